// File: rtl/axi_tdd_ng_sync_gen.sv
// Merges the external, internal-periodic and software sync sources into one tdd_sync strobe and counts issued syncs.
// Optional build macro TDD_SYNC_EXTERNAL_CDC_EN inserts a two-flop synchronizer ahead of the external edge detector.
module axi_tdd_ng_sync_gen #(
    parameter int SYNC_COUNT_WIDTH = 64,
    parameter int SYNC_STAT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tdd_enable,
    input  logic                        tdd_sync_int,
    input  logic                        tdd_sync_ext,
    input  logic                        tdd_sync_soft,
    input  logic                        sync_in,
    input  logic [SYNC_COUNT_WIDTH-1:0] asy_tdd_sync_period,
    output logic                        tdd_sync,
    output logic [SYNC_STAT_WIDTH-1:0]  tdd_sync_count
);

    logic                        w_ext_src;
    logic                        r_ext_d1;
    logic                        r_ext_d2;
    logic                        w_ext_pulse;
    logic                        w_int_run;
    logic                        w_period_zero;
    logic                        w_int_pulse;
    logic                        w_realign;
    logic                        w_sync_next;
    logic [SYNC_COUNT_WIDTH-1:0] r_period_cnt;
    logic [SYNC_COUNT_WIDTH-1:0] w_period_cnt_next;
    logic [SYNC_STAT_WIDTH-1:0]  w_count_next;
    logic                        r_tdd_sync;
    logic [SYNC_STAT_WIDTH-1:0]  r_tdd_sync_count;

`ifdef TDD_SYNC_EXTERNAL_CDC_EN
    (* ASYNC_REG = "TRUE" *) logic r_cdc_s1;
    (* ASYNC_REG = "TRUE" *) logic r_cdc_s2;

    // Two-flop synchronizer bringing the asynchronous sync pin into clk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdc_s1 <= 1'b0;
            r_cdc_s2 <= 1'b0;
        end else begin
            r_cdc_s1 <= sync_in;
            r_cdc_s2 <= r_cdc_s1;
        end
    end

    assign w_ext_src = r_cdc_s2;
`else
    assign w_ext_src = sync_in;
`endif

    // Edge-detect pipeline; free-running so an edge is only gated at the merge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_d1 <= 1'b0;
            r_ext_d2 <= 1'b0;
        end else begin
            r_ext_d1 <= w_ext_src;
            r_ext_d2 <= r_ext_d1;
        end
    end

    assign w_ext_pulse   = r_ext_d1 & ~r_ext_d2;
    assign w_int_run     = tdd_enable & tdd_sync_int;
    assign w_period_zero = (asy_tdd_sync_period == {SYNC_COUNT_WIDTH{1'b0}});
    // >= rather than == so a period shortened below the running count fires at once
    assign w_int_pulse   = w_int_run & ~w_period_zero &
                           (r_period_cnt >= (asy_tdd_sync_period - SYNC_COUNT_WIDTH'(1)));
    assign w_realign     = tdd_enable & ((w_ext_pulse & tdd_sync_ext) | tdd_sync_soft);
    assign w_sync_next   = tdd_enable & ((w_ext_pulse & tdd_sync_ext) | w_int_pulse | tdd_sync_soft);

    // Next period count: restart on terminal or on any accepted external/soft sync
    always_comb begin
        w_period_cnt_next = r_period_cnt;
        if (!w_int_run || w_period_zero || w_int_pulse || w_realign) begin
            w_period_cnt_next = {SYNC_COUNT_WIDTH{1'b0}};
        end else begin
            w_period_cnt_next = r_period_cnt + SYNC_COUNT_WIDTH'(1);
        end
    end

    // Next status count, advanced together with the strobe it counts
    always_comb begin
        w_count_next = r_tdd_sync_count;
        if (!tdd_enable) begin
            w_count_next = {SYNC_STAT_WIDTH{1'b0}};
        end else if (w_sync_next) begin
            w_count_next = r_tdd_sync_count + SYNC_STAT_WIDTH'(1);
        end else begin
            w_count_next = r_tdd_sync_count;
        end
    end

    // Registered period counter, strobe and status counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt     <= {SYNC_COUNT_WIDTH{1'b0}};
            r_tdd_sync       <= 1'b0;
            r_tdd_sync_count <= {SYNC_STAT_WIDTH{1'b0}};
        end else begin
            r_period_cnt     <= w_period_cnt_next;
            r_tdd_sync       <= w_sync_next;
            r_tdd_sync_count <= w_count_next;
        end
    end

    assign tdd_sync       = r_tdd_sync;
    assign tdd_sync_count = r_tdd_sync_count;

endmodule
